// File: rtl/remap_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | remap_pipe: two-stage leading-one normaliser, packs {k, m} with optional  |
// | round-half-up of the mantissa.                       Revision: 1.0        |
// +--------------------------------------------------------------------------+
module remap_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] num_i,
  input  logic             mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] rslt_o,
  output logic             zero_o
);

  localparam int KW = $clog2(WIDTH);
  localparam int MW = WIDTH - KW;

  logic             s1_v_q;
  logic [KW-1:0]    s1_k_q;
  logic [WIDTH-2:0] s1_f_q;
  logic             s1_zero_q;
  logic             s1_mode_q;

  logic             s2_v_q;
  logic [WIDTH-1:0] s2_rslt_q;
  logic             s2_zero_q;

  logic             adv1;
  logic             adv2;
  logic [KW-1:0]    k_d;
  logic [KW-1:0]    shamt;
  logic [WIDTH-2:0] f_d;
  logic [MW-1:0]    mant;
  logic             rbit;
  logic [MW:0]      sum;
  logic [WIDTH-1:0] rslt_d;
  logic             unused_lsbs;

  assign adv2       = !s2_v_q || out_ready_i;
  assign adv1       = !s1_v_q || adv2;
  assign in_ready_o = adv1;

  // Leading-one index; the highest set bit wins because it is visited last.
  always_comb begin
    k_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (num_i[i]) k_d = KW'(i);
    end
  end

  // Shifting the lower WIDTH-1 bits pushes the leading one out the top,
  // leaving only the fraction bits below it, left-aligned.
  assign shamt = KW'(WIDTH - 1) - k_d;
  assign f_d   = num_i[WIDTH-2:0] << shamt;

  assign mant        = s1_f_q[WIDTH-2 -: MW];
  assign rbit        = s1_mode_q & s1_f_q[KW-2];
  assign sum         = {1'b0, mant} + {{MW{1'b0}}, rbit};
  assign unused_lsbs = ^s1_f_q[KW-2:0];

  always_comb begin
    rslt_d = {s1_k_q, sum[MW-1:0]};
    if (s1_zero_q) begin
      rslt_d = '0;
    end else if (sum[MW]) begin
      // Mantissa carry bumps the exponent, or saturates at the top exponent.
      if (s1_k_q == {KW{1'b1}}) rslt_d = '1;
      else                      rslt_d = {s1_k_q + KW'(1), {MW{1'b0}}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_rslt_q <= '0;
      s2_zero_q <= 1'b0;
    end else begin
      if (adv1) begin
        s1_v_q <= in_valid_i;
        if (in_valid_i) begin
          s1_k_q    <= k_d;
          s1_f_q    <= f_d;
          s1_zero_q <= (num_i == '0);
          s1_mode_q <= mode_i;
        end
      end
      if (adv2) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_rslt_q <= rslt_d;
          s2_zero_q <= s1_zero_q;
        end
      end
    end
  end

  assign out_valid_o = s2_v_q;
  assign rslt_o      = s2_rslt_q;
  assign zero_o      = s2_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_remap_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_remap_pipe: scoreboard bench for remap_pipe at WIDTH=32.               |
// |                                                      Revision: 1.0        |
// +--------------------------------------------------------------------------+
module tb_remap_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] num = '0;
  logic        mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] rslt;
  logic        zero;

  int total = 0;
  int bad   = 0;

  // Hand-computed vectors: operand, mode, expected result, expected zero flag.
  logic [31:0] V_NUM  [16] = '{32'h00000001, 32'h00000000, 32'h80000000, 32'h80000000,
                               32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'h00000003, 32'h0000001F, 32'h80000018, 32'h80000018,
                               32'h12345678, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h00000000};
  logic        V_MODE [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [31:0] V_EXP  [16] = '{32'h00000000, 32'h00000000, 32'hF8000000, 32'hF8000000,
                               32'hF7FFFFFF, 32'hF8000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'h0C000000, 32'h27800000, 32'hF8000001, 32'hF8000002,
                               32'hE11A2B3C, 32'hF0000000, 32'hEFFFFFFF, 32'h00000000};
  logic        V_ZERO [16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  int          sb[$];
  logic        hold_q  = 1'b0;
  logic [31:0] hold_r  = '0;
  logic        hold_z  = 1'b0;
  logic        stream_phase = 1'b0;
  logic        seen_block   = 1'b0;

  remap_pipe #(.WIDTH(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .num_i      (num),
    .mode_i     (mode),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .rslt_o     (rslt),
    .zero_o     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations on output transfers and checks stall stability.
  always @(negedge clk) begin
    if (hold_q) begin
      check("hold_valid", {31'b0, out_valid}, 32'h1);
      check("hold_rslt", rslt, hold_r);
      check("hold_zero", {31'b0, zero}, {31'b0, hold_z});
    end
    hold_q <= out_valid && !out_ready && !rst;
    hold_r <= rslt;
    hold_z <= zero;
    if (stream_phase && in_valid && !in_ready) seen_block <= 1'b1;
    if (out_valid && out_ready && !rst) begin
      if (sb.size() == 0) begin
        check("unexpected_output", rslt, 32'hxxxxxxxx);
      end else begin
        int idx;
        idx = sb.pop_front();
        check($sformatf("rslt[%0d]", idx), rslt, V_EXP[idx]);
        check($sformatf("zero[%0d]", idx), {31'b0, zero}, {31'b0, V_ZERO[idx]});
      end
    end
  end

  task automatic send(input int idx);
    in_valid = 1'b1;
    num      = V_NUM[idx];
    mode     = V_MODE[idx];
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        sb.push_back(idx);
        break;
      end
      if (c > 200) begin
        check("send_timeout", 32'h0, 32'h1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && sb.size() != 0; c++) @(posedge clk);
    check("drain_left", sb.size(), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_rslt", rslt, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-cycle latency into an empty pipeline.
    send(0);
    @(negedge clk);
    check("lat_cycle1_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    check("lat_cycle2_valid", {31'b0, out_valid}, 32'h1);
    drain();

    for (int i = 1; i < 16; i++) begin
      send(i);
      drain();
    end

    // Back-to-back stream with a 3-cycle downstream stall.
    stream_phase = 1'b1;
    fork
      begin
        for (int i = 8; i < 16; i++) send(i);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    stream_phase = 1'b0;
    check("in_ready_dropped", {31'b0, seen_block}, 32'h1);

    // Fill both stages, then reset for one cycle.
    out_ready = 1'b0;
    send(2);
    send(6);
    @(negedge clk);
    check("full_out_valid", {31'b0, out_valid}, 32'h1);
    check("full_in_ready", {31'b0, in_ready}, 32'h0);
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    num      = 32'h12345678;
    mode     = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {31'b0, out_valid}, 32'h0);
    check("post_rst_rslt", rslt, 32'h0);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(13);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/remap_pipe.md
REMAP_PIPE -- requirements
Module: remap_pipe

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 Derived localparam KW = log2(WIDTH) is the exponent field width.
REQ-003 Derived localparam MW = WIDTH-KW is the mantissa field width.
REQ-004 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 in_valid_i  input  1  num_i and mode_i are valid.
REQ-007 in_ready_o  output  1  block accepts an input this cycle.
REQ-008 num_i  input  WIDTH  unsigned operand.
REQ-009 mode_i  input  1  0 = truncate mantissa, 1 = round half-up.
REQ-010 out_valid_o  output  1  rslt_o and zero_o are valid.
REQ-011 out_ready_i  input  1  downstream accepts the result this cycle.
REQ-012 rslt_o  output  WIDTH  result {k[KW-1:0], m[MW-1:0]}.
REQ-013 zero_o  output  1  set when the operand was zero.

Function
REQ-014 A transfer SHALL occur on a port in any cycle where valid and ready are both high.
REQ-015 mode_i SHALL be captured together with num_i at input transfer.
REQ-016 k SHALL be the bit index of the most significant set bit of num_i.
REQ-017 f SHALL be the WIDTH-1 bits below that leading one, left-aligned, with zero fill.
REQ-018 In truncate mode, m SHALL equal f[WIDTH-2 -: MW].
REQ-019 In round mode, m SHALL equal f[WIDTH-2 -: MW] + f[KW-2], where f[KW-2] is the MSB of the KW-1 discarded bits.
REQ-020 If the rounding add overflows MW bits and k < WIDTH-1, the result SHALL be k+1 with m = 0.
REQ-021 If the rounding add overflows MW bits and k = WIDTH-1, rslt_o SHALL saturate to all ones.
REQ-022 For num_i = 0, rslt_o SHALL be 0 and zero_o SHALL be 1; otherwise zero_o SHALL be 0.
REQ-023 Stage S1 SHALL register k, f, the zero flag and mode.
REQ-024 Stage S2 SHALL register the rounded and packed result that drives rslt_o and zero_o.
REQ-025 Each stage SHALL hold a valid bit: s1_v and s2_v.
REQ-026 Latency SHALL be exactly 2 cycles from input transfer to out_valid_o when no stall occurs.
REQ-027 Define adv2 = !s2_v | out_ready_i and adv1 = !s1_v | adv2.
REQ-028 in_ready_o SHALL equal adv1; a combinational path from out_ready_i to in_ready_o is permitted.
REQ-029 Throughput SHALL be one result per cycle while out_ready_i stays high.
REQ-030 When out_valid_o=1 and out_ready_i=0, rslt_o, zero_o and out_valid_o SHALL hold stable.
REQ-031 A stage that does not advance SHALL keep its contents; no data SHALL be dropped or duplicated.
REQ-032 In-order delivery SHALL be maintained.
REQ-033 When out_ready_i rises and in_valid_i=1 in the same cycle, S2 SHALL drain, S1 SHALL move to S2, and the new input SHALL load S1, all in that cycle.
REQ-034 in_valid_i with in_ready_o=0 SHALL have no effect on state.

Reset
REQ-035 While rst_i=1 at a clock edge, s1_v and s2_v SHALL clear to 0.
REQ-036 During reset, out_valid_o SHALL be 0 from the next cycle.
REQ-037 During reset, rslt_o and zero_o SHALL be 0 from the next cycle.
REQ-038 Reset asserted mid-operation SHALL discard all in-flight items; no result for them SHALL appear after reset.
REQ-039 During reset, in_ready_o SHALL be 1 (both stages empty); inputs transferred in a cycle where rst_i=1 SHALL be discarded.

Verification (WIDTH=32, KW=5, MW=27)
REQ-040 num=0x00000001, mode=0 -> after 2 cycles rslt_o=0x00000000, zero_o=0; num=0 -> rslt_o=0x00000000, zero_o=1.
REQ-041 num=0x80000000, mode=0 or 1 -> rslt_o=0xF8000000.
REQ-042 num=0x7FFFFFFF, mode=0 -> rslt_o=0xF7FFFFFF; mode=1 -> rslt_o=0xF8000000 (mantissa carry into k).
REQ-043 num=0xFFFFFFFF, mode=1 -> rslt_o=0xFFFFFFFF (saturation); mode=0 -> rslt_o=0xFFFFFFFF.
REQ-044 Back-to-back stream of 8 operands with out_ready_i held low for 3 cycles mid-stream -> in_ready_o drops after both stages fill, outputs are held stable, and all 8 results arrive in order with no loss or duplicates.
REQ-045 Assert rst_i for 1 cycle with both stages full -> out_valid_o=0 the next cycle and no stale result is emitted afterward.
